// File: rtl/hub75_frame_scanner.sv
// hub75_frame_scanner: double-buffered palette frame store scanned out to a HUB75 panel, two rows at a time
module hub75_frame_scanner #(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int PIX_W = 2,
  parameter int DWELL = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [PIX_W-1:0]          wr_pix,
  input  logic                      swap_req,
  output logic                      swap_ack,
  input  logic [3*2**PIX_W-1:0]     pal,
  output logic                      r0,
  output logic                      g0,
  output logic                      b0,
  output logic                      r1,
  output logic                      g1,
  output logic                      b1,
  output logic                      sclk_out,
  output logic [$clog2(ROWS/2)-1:0] a,
  output logic                      lch,
  output logic                      blank,
  output logic                      frame_done
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(ROWS / 2);
  localparam int DW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] row_q, row_d, a_q, a_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic phase_q, phase_d, front_q, front_d, pend_q, pend_d;
  logic [2:0] rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic sclk_q, sclk_d, lch_q, lch_d, blank_q, blank_d, done_q, done_d, ack_q, ack_d;
  logic [PIX_W-1:0] bank_mem [2][ROWS][COLS];
  logic [2:0] pal_e [2**PIX_W];
  logic [RW-1:0] bot_row;
  logic last_col, last_dwell, last_row, eof, swap, wr_ok;
  for (genvar i = 0; i < 2**PIX_W; i++) assign pal_e[i] = pal[3*i +: 3];
  assign wr_ok = wr_en && 32'(wr_row) < ROWS && 32'(wr_col) < COLS;
  // Pixel writes always land in the back bank; contents survive reset
  always_ff @(posedge clk)
    if (wr_ok) bank_mem[!front_q][wr_row][wr_col] <= wr_pix;
  // Scan sequencing, swap handshake and next values of the registered panel outputs
  always_comb begin
    last_col   = col_q == CW'(COLS - 1);
    last_dwell = dwell_q == DW'(DWELL - 1);
    last_row   = row_q == AW'(ROWS / 2 - 1);
    eof        = state_q == DISPLAY && last_dwell && last_row;
    swap       = eof && (pend_q || swap_req);
    bot_row    = RW'(row_q) + RW'(ROWS / 2);
    state_d    = state_q == SHIFT ? (phase_q && last_col ? BLANK : SHIFT) :
                 state_q == BLANK ? LATCH : state_q == LATCH ? DISPLAY :
                 last_dwell ? SHIFT : DISPLAY;
    phase_d    = state_q == SHIFT && !phase_q;
    col_d      = state_q == SHIFT && phase_q ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    dwell_d    = state_q == DISPLAY && !last_dwell ? dwell_q + DW'(1) : '0;
    row_d      = state_q == DISPLAY && last_dwell ? (last_row ? '0 : row_q + AW'(1)) : row_q;
    front_d    = front_q ^ swap;
    pend_d     = !swap && (pend_q || swap_req);
    rgb0_d     = state_q == SHIFT && !phase_q ? pal_e[bank_mem[front_q][RW'(row_q)][col_q]] : rgb0_q;
    rgb1_d     = state_q == SHIFT && !phase_q ? pal_e[bank_mem[front_q][bot_row][col_q]] : rgb1_q;
    sclk_d     = state_q == SHIFT && phase_q;
    lch_d      = state_q == LATCH;
    a_d        = state_q == LATCH ? row_q : a_q;
    blank_d    = state_q == BLANK ? 1'b1 : state_q == DISPLAY ? 1'b0 : blank_q;
    done_d     = eof;
    ack_d      = swap;
  end
  // State and output registers; reset aborts the current row and darkens the panel
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= SHIFT;
      row_q   <= '0;
      col_q   <= '0;
      dwell_q <= '0;
      phase_q <= 1'b0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
      sclk_q  <= 1'b0;
      lch_q   <= 1'b0;
      a_q     <= '0;
      blank_q <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      phase_q <= phase_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      sclk_q  <= sclk_d;
      lch_q   <= lch_d;
      a_q     <= a_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  assign {r0, g0, b0} = rgb0_q;
  assign {r1, g1, b1} = rgb1_q;
  assign sclk_out   = sclk_q;
  assign lch        = lch_q;
  assign a          = a_q;
  assign blank      = blank_q;
  assign frame_done = done_q;
  assign swap_ack   = ack_q;
endmodule

// File: tb/tb_hub75_frame_scanner.sv
// tb_hub75_frame_scanner: random writes and swaps on a 32-column and a 24-column panel, checked against a frame-timing model
module tb_hub75_frame_scanner;
  localparam int HALF = 16, DWELL = 64, F0 = 2080;
  logic clk = 0, reset = 1, wr_en = 0, swap_req = 0;
  logic [4:0] wr_row = 0, wr_col = 0;
  logic [1:0] wr_pix = 0;
  logic [11:0] pal = {3'b010, 3'b001, 3'b100, 3'b000};
  logic [1:0] r0, g0, b0, r1, g1, b1, sclk, lch, blank, fd, ack;
  logic [3:0] a_o [2];
  int cols [2] = '{32, 24};
  logic [1:0] bank [2][2][32][32];
  bit known [2][2][32][32];
  bit front [2], pend [2], v0 [2], v1 [2];
  logic [2:0] e_rgb0 [2], e_rgb1 [2];
  bit e_sclk [2], e_lch [2], e_blank [2], e_fd [2], e_ack [2];
  int e_a [2];
  int cyc, n_chk, n_fail, acks0;

  always #5 clk = ~clk;

  hub75_frame_scanner #(.ROWS(32), .COLS(32), .PIX_W(2), .DWELL(64)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_pix(wr_pix),
    .swap_req(swap_req), .swap_ack(ack[0]), .pal(pal), .r0(r0[0]), .g0(g0[0]), .b0(b0[0]),
    .r1(r1[0]), .g1(g1[0]), .b1(b1[0]), .sclk_out(sclk[0]), .a(a_o[0]), .lch(lch[0]),
    .blank(blank[0]), .frame_done(fd[0]));

  hub75_frame_scanner #(.ROWS(32), .COLS(24), .PIX_W(2), .DWELL(64)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_pix(wr_pix),
    .swap_req(swap_req), .swap_ack(ack[1]), .pal(pal), .r0(r0[1]), .g0(g0[1]), .b0(b0[1]),
    .r1(r1[1]), .g1(g1[1]), .b1(b1[1]), .sclk_out(sclk[1]), .a(a_o[1]), .lch(lch[1]),
    .blank(blank[1]), .frame_done(fd[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] pcol(input logic [1:0] p);
    return pal[int'(p) * 3 +: 3];
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      front[i] = 0; pend[i] = 0; e_rgb0[i] = 0; e_rgb1[i] = 0; v0[i] = 1; v1[i] = 1;
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d rst blank", i), 32'(blank[i]), 1);
      chk($sformatf("u%0d rst lch", i), 32'(lch[i]), 0);
      chk($sformatf("u%0d rst sclk", i), 32'(sclk[i]), 0);
      chk($sformatf("u%0d rst a", i), 32'(a_o[i]), 0);
      chk($sformatf("u%0d rst ack", i), 32'(ack[i]), 0);
      chk($sformatf("u%0d rst done", i), 32'(fd[i]), 0);
      chk($sformatf("u%0d rst rgb0", i), 32'({r0[i], g0[i], b0[i]}), 0);
    end
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) begin
      int p, f, fr, r, o, c2;
      c2 = 2 * cols[i];
      p = c2 + 2 + DWELL;
      f = HALF * p;
      fr = cyc % f;
      r = fr / p;
      o = fr % p;
      e_sclk[i] = o < c2 && o % 2 == 1;
      e_lch[i] = o == c2 + 1;
      e_blank[i] = o < c2 ? cyc < p : o < c2 + 2;
      e_a[i] = o > c2 ? r : cyc < p ? 0 : (r + HALF - 1) % HALF;
      e_fd[i] = fr == f - 1;
      e_ack[i] = e_fd[i] && (pend[i] || swap_req);
      if (o < c2 && o % 2 == 0) begin
        e_rgb0[i] = pcol(bank[i][front[i]][r][o / 2]);
        v0[i] = known[i][front[i]][r][o / 2];
        e_rgb1[i] = pcol(bank[i][front[i]][r + HALF][o / 2]);
        v1[i] = known[i][front[i]][r + HALF][o / 2];
      end
      if (wr_en && int'(wr_col) < cols[i]) begin
        bank[i][!front[i]][wr_row][wr_col] = wr_pix;
        known[i][!front[i]][wr_row][wr_col] = 1;
      end
      if (e_ack[i]) begin
        front[i] = !front[i];
        pend[i] = 0;
      end else pend[i] = pend[i] || swap_req;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d sclk", i), 32'(sclk[i]), 32'(e_sclk[i]));
      chk($sformatf("u%0d lch", i), 32'(lch[i]), 32'(e_lch[i]));
      chk($sformatf("u%0d blank", i), 32'(blank[i]), 32'(e_blank[i]));
      chk($sformatf("u%0d a", i), 32'(a_o[i]), e_a[i]);
      chk($sformatf("u%0d frame_done", i), 32'(fd[i]), 32'(e_fd[i]));
      chk($sformatf("u%0d swap_ack", i), 32'(ack[i]), 32'(e_ack[i]));
      if (v0[i]) chk($sformatf("u%0d rgb0", i), 32'({r0[i], g0[i], b0[i]}), 32'(e_rgb0[i]));
      if (v1[i]) chk($sformatf("u%0d rgb1", i), 32'({r1[i], g1[i], b1[i]}), 32'(e_rgb1[i]));
    end
    if (ack[0]) acks0++;
    cyc++;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset();
    reset = 0;
    repeat (266) step();
    #2 reset = 1;
    #1 chk_reset();
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    for (int k = 0; k < 4 * F0 + 200; k++) begin
      wr_en = 1'($urandom_range(1));
      wr_row = 5'($urandom_range(31));
      wr_col = 5'($urandom_range(31));
      wr_pix = 2'($urandom_range(3));
      swap_req = k == 10 || k == F0 + 300 || k == F0 + 700 || k == F0 + 1100 || k == 3 * F0 - 1;
      if (k == 0) {wr_en, wr_row, wr_col, wr_pix} = {1'b1, 5'd0, 5'd0, 2'd1};
      if (k == 1) {wr_en, wr_row, wr_col, wr_pix} = {1'b1, 5'd16, 5'd0, 2'd2};
      if (k == 2) {wr_en, wr_row, wr_col, wr_pix} = {1'b1, 5'd3, 5'd30, 2'd3};
      if (k == 2 * F0 - 1) {wr_en, wr_row, wr_col, wr_pix} = {1'b1, 5'd1, 5'd5, 2'd3};
      if (k == F0 + 299) acks0 = 0;
      if (k == 2 * F0 + 10) chk("u0 merged swap acks", acks0, 1);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
